// File: rtl/myo_spi_pkg.sv
// Shared constants and FSM state type for the myocontrol SPI responder.
package myo_spi_pkg;

  localparam int unsigned DEFAULT_WORD_W    = 16;
  localparam int unsigned DEFAULT_NUM_WORDS = 12;
  localparam int unsigned SYNC_STAGES       = 2;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } spi_state_e;

endpackage

// File: rtl/myo_spi_responder_if.sv
// SPI pin bundle between the fabric-side master and the motor-board responder.
interface myo_spi_responder_if;

  logic ss_n;
  logic sck;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (
    output ss_n,
    output sck,
    output mosi,
    input  miso,
    input  miso_oe
  );

  modport slave (
    input  ss_n,
    input  sck,
    input  mosi,
    output miso,
    output miso_oe
  );

endinterface

// File: rtl/myo_spi_sync.sv
// Single-bit synchronizer for an asynchronous pin, followed by an edge register that
// produces one-cycle rise/fall pulses aligned with the synchronized level.
module myo_spi_sync
  import myo_spi_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  // Clearing to 0 means a pin held low through reset never produces a fall pulse until
  // it has first been seen high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~edge_q;
  assign fall_o  = ~level_o & edge_q;

endmodule

// File: rtl/myo_spi_responder.sv
// SPI mode-0 slave standing in for a myocontrol motor board: returns a frame of status words
// and captures command words. Define MYO_SPI_RESP_CHECKSUM_EN for a last-word sum check.
module myo_spi_responder
  import myo_spi_pkg::*;
#(
  parameter int unsigned WORD_W    = DEFAULT_WORD_W,
  parameter int unsigned NUM_WORDS = DEFAULT_NUM_WORDS
) (
  input  logic                        clk,
  input  logic                        reset,
  myo_spi_responder_if.slave          spi,
  input  logic [NUM_WORDS*WORD_W-1:0] tx_data,
  output logic [NUM_WORDS*WORD_W-1:0] rx_data,
  output logic                        rx_valid,
  output logic                        rx_err,
  output logic                        busy
);

  localparam int unsigned BitCntW  = $clog2(WORD_W);
  localparam int unsigned WordCntW = $clog2(NUM_WORDS + 1);
  localparam logic [BitCntW-1:0]  BitLast   = BitCntW'(WORD_W - 1);
  localparam logic [WordCntW-1:0] WordsFull = WordCntW'(NUM_WORDS);

  logic ss_rise, ss_fall, ss_level_unused;
  logic sck_rise, sck_fall, sck_level_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  myo_spi_sync u_sync_ss (
    .clk     (clk),
    .reset   (reset),
    .d_i     (spi.ss_n),
    .level_o (ss_level_unused),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  myo_spi_sync u_sync_sck (
    .clk     (clk),
    .reset   (reset),
    .d_i     (spi.sck),
    .level_o (sck_level_unused),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  myo_spi_sync u_sync_mosi (
    .clk     (clk),
    .reset   (reset),
    .d_i     (spi.mosi),
    .level_o (mosi_s),
    .rise_o  (mosi_rise_unused),
    .fall_o  (mosi_fall_unused)
  );

  spi_state_e           state_q;
  logic [BitCntW-1:0]   bit_cnt_q;
  logic [WordCntW-1:0]  word_cnt_q;
  logic                 overrun_q;
  logic                 pending_q;
  logic [WORD_W-1:0]    tx_shift_q;
  logic [WORD_W-1:0]    rx_shift_q;
  logic [WORD_W-1:0]    tx_buf_q [NUM_WORDS];
  logic [WORD_W-1:0]    rx_buf_q [NUM_WORDS];
  logic                 miso_q;
  logic                 miso_oe_q;
  logic                 busy_q;
  logic                 rx_valid_q;
  logic                 rx_err_q;
  logic [NUM_WORDS*WORD_W-1:0] rx_data_q;

  logic [WORD_W-1:0]           tx_words [NUM_WORDS];
  logic [NUM_WORDS*WORD_W-1:0] rx_buf_flat;
  logic [WORD_W-1:0]           rx_word_in;
  logic                        csum_ok;
  logic                        frame_good;

`ifdef MYO_SPI_RESP_CHECKSUM_EN
  logic [WORD_W-1:0] tx_sum;
  logic [WORD_W-1:0] rx_sum;

  // Outgoing last word is replaced by the running sum of the preceding status words.
  always_comb begin
    tx_sum = '0;
    for (int k = 0; k < NUM_WORDS - 1; k++) begin
      tx_sum = tx_sum + tx_data[k*WORD_W +: WORD_W];
    end
    for (int k = 0; k < NUM_WORDS; k++) begin
      tx_words[k] = tx_data[k*WORD_W +: WORD_W];
    end
    tx_words[NUM_WORDS-1] = tx_sum;
  end

  always_comb begin
    rx_sum = '0;
    for (int k = 0; k < NUM_WORDS - 1; k++) begin
      rx_sum = rx_sum + rx_buf_q[k];
    end
  end

  assign csum_ok = (rx_sum == rx_buf_q[NUM_WORDS-1]);
`else
  always_comb begin
    for (int k = 0; k < NUM_WORDS; k++) begin
      tx_words[k] = tx_data[k*WORD_W +: WORD_W];
    end
  end

  assign csum_ok = 1'b1;
`endif

  always_comb begin
    rx_buf_flat = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      rx_buf_flat[k*WORD_W +: WORD_W] = rx_buf_q[k];
    end
  end

  assign rx_word_in = {rx_shift_q[WORD_W-2:0], mosi_s};
  assign frame_good = (word_cnt_q == WordsFull) && (bit_cnt_q == '0) && !overrun_q && csum_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      overrun_q  <= 1'b0;
      pending_q  <= 1'b0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_data_q  <= '0;
      for (int k = 0; k < NUM_WORDS; k++) begin
        tx_buf_q[k] <= '0;
        rx_buf_q[k] <= '0;
      end
    end else begin
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (ss_fall || pending_q) begin
            state_q    <= StShift;
            pending_q  <= 1'b0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b1;
            miso_oe_q  <= 1'b1;
            for (int k = 0; k < NUM_WORDS; k++) begin
              tx_buf_q[k] <= tx_words[k];
            end
            miso_q     <= tx_words[0][WORD_W-1];
            tx_shift_q <= {tx_words[0][WORD_W-2:0], 1'b0};
          end
        end

        StShift: begin
          if (ss_rise) begin
            state_q   <= StDone;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
          end else begin
            // Master samples on the rising edge; bits past the full frame are dropped.
            if (sck_rise) begin
              if (word_cnt_q == WordsFull) begin
                overrun_q <= 1'b1;
              end else begin
                rx_shift_q <= rx_word_in;
                if (bit_cnt_q == BitLast) begin
                  bit_cnt_q            <= '0;
                  rx_buf_q[word_cnt_q] <= rx_word_in;
                  word_cnt_q           <= word_cnt_q + 1'b1;
                end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                end
              end
            end
            if (sck_fall) begin
              if (word_cnt_q == WordsFull) begin
                miso_q <= 1'b0;
              end else if (bit_cnt_q == '0) begin
                miso_q     <= tx_buf_q[word_cnt_q][WORD_W-1];
                tx_shift_q <= {tx_buf_q[word_cnt_q][WORD_W-2:0], 1'b0};
              end else begin
                miso_q     <= tx_shift_q[WORD_W-1];
                tx_shift_q <= {tx_shift_q[WORD_W-2:0], 1'b0};
              end
            end
          end
        end

        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          // A new select arriving during this cycle starts the next frame right after.
          if (ss_fall) begin
            pending_q <= 1'b1;
          end
          if (frame_good) begin
            rx_data_q  <= rx_buf_flat;
            rx_valid_q <= 1'b1;
          end else begin
            rx_err_q <= 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign spi.miso    = miso_q;
  assign spi.miso_oe = miso_oe_q;
  assign busy        = busy_q;
  assign rx_valid    = rx_valid_q;
  assign rx_err      = rx_err_q;
  assign rx_data     = rx_data_q;

endmodule

// File: tb/tb_myo_spi_responder.sv
// Bench for myo_spi_responder: drives SPI frames from a bit-level master and checks miso,
// rx_data and pulse timing against a word-level frame model.
module tb_myo_spi_responder;
  import myo_spi_pkg::*;

  localparam int W  = DEFAULT_WORD_W;
  localparam int N  = DEFAULT_NUM_WORDS;
  localparam int FW = W * N;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic [FW-1:0] tx_data  = '0;
  logic [FW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_err;
  logic          busy;

  myo_spi_responder_if spi_if ();

  myo_spi_responder #(
    .WORD_W    (W),
    .NUM_WORDS (N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .spi      (spi_if),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int            compared   = 0;
  int            mismatched = 0;
  int            cyc        = 0;
  int            valid_cyc[$];
  int            err_cyc[$];
  logic [FW-1:0] valid_data[$];
  logic [W-1:0]  mosi_words [16];
  logic          miso_bits [256];
  int            ss_rise_cyc = 0;
  int            chg_bit     = -1;
  logic [FW-1:0] chg_val     = '0;
  int            rst_bit     = -1;
  logic [FW-1:0] last_good   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      valid_cyc.push_back(cyc);
      valid_data.push_back(rx_data);
    end
    if (rx_err === 1'b1) err_cyc.push_back(cyc);
  end

  // Reference model: what the master should read back for status word k of a snapshot.
  function automatic logic [W-1:0] tx_word(input logic [FW-1:0] td, input int k);
`ifdef MYO_SPI_RESP_CHECKSUM_EN
    logic [W-1:0] s = '0;
    if (k == N - 1) begin
      for (int i = 0; i < N - 1; i++) s = s + td[i*W +: W];
      return s;
    end
`endif
    return td[k*W +: W];
  endfunction

  function automatic logic [FW-1:0] mosi_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < N; k++) f[k*W +: W] = mosi_words[k];
    return f;
  endfunction

  function automatic bit frame_good(input int nbits);
`ifdef MYO_SPI_RESP_CHECKSUM_EN
    logic [W-1:0] s = '0;
    for (int i = 0; i < N - 1; i++) s = s + mosi_words[i];
    if (s != mosi_words[N-1]) return 1'b0;
`endif
    return nbits == FW;
  endfunction

  function automatic logic [W-1:0] miso_word(input int k);
    logic [W-1:0] v;
    for (int b = 0; b < W; b++) v[W-1-b] = miso_bits[k*W+b];
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fix_checksum();
`ifdef MYO_SPI_RESP_CHECKSUM_EN
    logic [W-1:0] s = '0;
    for (int i = 0; i < N - 1; i++) s = s + mosi_words[i];
    mosi_words[N-1] = s;
`endif
  endtask

  task automatic randomize_words();
    for (int k = 0; k < 16; k++) mosi_words[k] = W'($urandom);
    for (int k = 0; k < N; k++) tx_data[k*W +: W] = W'($urandom);
  endtask

  task automatic clear_events();
    valid_cyc.delete();
    err_cyc.delete();
    valid_data.delete();
  endtask

  // Mode-0 master at sck = clk/10: mosi set while sck low, miso sampled just before the rise.
  task automatic spi_xfer(input int nbits);
    spi_if.ss_n = 1'b0;
    tick(6);
    for (int b = 0; b < nbits; b++) begin
      spi_if.mosi = mosi_words[b/W][W-1-(b%W)];
      if (b == chg_bit) tx_data = chg_val;
      if (b == rst_bit) begin
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
      end
      tick(5);
      miso_bits[b] = spi_if.miso;
      spi_if.sck = 1'b1;
      tick(5);
      spi_if.sck = 1'b0;
    end
    tick(5);
    spi_if.ss_n = 1'b1;
    ss_rise_cyc = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(4);
    compared++;
    if ({spi_if.miso, spi_if.miso_oe, busy, rx_valid, rx_err} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {spi_if.miso, spi_if.miso_oe, busy, rx_valid, rx_err});
    end
    compared++;
    if (rx_data !== '0) begin
      mismatched++;
      $display("FAIL reset_rx_data: got %h expected 0", rx_data);
    end
    reset = 1'b0;
    tick(6);
    compared++;
    if ({spi_if.miso, spi_if.miso_oe, busy, rx_valid, rx_err} !== 5'b0) begin
      mismatched++;
      $display("FAIL idle_outputs: got %b expected 00000",
               {spi_if.miso, spi_if.miso_oe, busy, rx_valid, rx_err});
    end
  endtask

  // One frame of nbits from the current stimulus, checked word-by-word and for its outcome.
  task automatic run_and_check(input string name, input int nbits);
    logic [FW-1:0] snap;
    bit            good;
    int            full;
    snap = tx_data;
    good = frame_good(nbits);
    clear_events();
    spi_xfer(nbits);
    tick(8);
    full = (nbits / W < N) ? nbits / W : N;
    for (int k = 0; k < full; k++) begin
      compared++;
      if (miso_word(k) !== tx_word(snap, k)) begin
        mismatched++;
        $display("FAIL %s_miso_w%0d: got %h expected %h", name, k, miso_word(k), tx_word(snap, k));
      end
    end
    compared++;
    if (good ? !(valid_cyc.size() == 1 && err_cyc.size() == 0 && valid_cyc[0] == ss_rise_cyc + 4)
             : !(err_cyc.size() == 1 && valid_cyc.size() == 0 && err_cyc[0] == ss_rise_cyc + 4))
    begin
      mismatched++;
      $display("FAIL %s_pulse: got %0d valid / %0d err, expected one %s at cycle %0d",
               name, valid_cyc.size(), err_cyc.size(), good ? "valid" : "err", ss_rise_cyc + 4);
    end
    if (good) last_good = mosi_frame();
    compared++;
    if (rx_data !== last_good) begin
      mismatched++;
      $display("FAIL %s_rx_data: got %h expected %h", name, rx_data, last_good);
    end
  endtask

  task automatic test_nominal();
    for (int k = 0; k < N; k++) begin
      tx_data[k*W +: W] = W'(32'hA000 + k);
      mosi_words[k]     = W'(32'h1000 + k);
    end
    run_and_check("nominal", FW);
  endtask

  task automatic test_short();
    randomize_words();
    fix_checksum();
    run_and_check("short", 5 * W + 3);
  endtask

  task automatic test_overrun();
    logic [7:0] extra;
    randomize_words();
    fix_checksum();
    tx_data[W-1:0] = '1;
    run_and_check("overrun", FW + 8);
    for (int b = 0; b < 8; b++) extra[7-b] = miso_bits[FW+b];
    compared++;
    if (extra !== 8'h00) begin
      mismatched++;
      $display("FAIL overrun_miso_extra: got %h expected 00", extra);
    end
  endtask

  task automatic test_snapshot();
    randomize_words();
    fix_checksum();
    chg_bit = 3 * W + 7;
    chg_val = ~tx_data;
    run_and_check("snapshot", FW);
    chg_bit = -1;
  endtask

  task automatic test_reset_mid();
    randomize_words();
    fix_checksum();
    clear_events();
    rst_bit = 4 * W + 6;
    spi_xfer(FW);
    rst_bit = -1;
    last_good = '0;
    tick(8);
    compared++;
    if (valid_cyc.size() != 0 || err_cyc.size() != 0) begin
      mismatched++;
      $display("FAIL reset_mid_pulse: got %0d valid / %0d err expected 0 / 0",
               valid_cyc.size(), err_cyc.size());
    end
    compared++;
    if ({busy, rx_data} !== '0) begin
      mismatched++;
      $display("FAIL reset_mid_state: got busy %b rx_data %h expected 0 / 0", busy, rx_data);
    end
    randomize_words();
    fix_checksum();
    run_and_check("after_reset", FW);
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] exp1, exp2, snap;
    int            r1;
    randomize_words();
    fix_checksum();
    snap = tx_data;
    exp1 = mosi_frame();
    clear_events();
    spi_xfer(FW);
    r1 = ss_rise_cyc;
    tick(1);
    for (int k = 0; k < N; k++) mosi_words[k] = W'($urandom);
    fix_checksum();
    exp2 = mosi_frame();
    spi_xfer(FW);
    tick(8);
    compared++;
    if (!(valid_cyc.size() == 2 && err_cyc.size() == 0 && valid_cyc[0] == r1 + 4 &&
          valid_cyc[1] == ss_rise_cyc + 4)) begin
      mismatched++;
      $display("FAIL b2b_pulse: got %0d valid / %0d err expected 2 valid at %0d and %0d",
               valid_cyc.size(), err_cyc.size(), r1 + 4, ss_rise_cyc + 4);
    end else begin
      compared++;
      if (valid_data[0] !== exp1 || valid_data[1] !== exp2) begin
        mismatched++;
        $display("FAIL b2b_data: got %h / %h expected %h / %h",
                 valid_data[0], valid_data[1], exp1, exp2);
      end
    end
    for (int k = 0; k < N; k++) begin
      compared++;
      if (miso_word(k) !== tx_word(snap, k)) begin
        mismatched++;
        $display("FAIL b2b_miso_w%0d: got %h expected %h", k, miso_word(k), tx_word(snap, k));
      end
    end
    last_good = exp2;
  endtask

  task automatic test_random();
    int nbits;
    for (int i = 0; i < 4; i++) begin
      randomize_words();
      if ($urandom_range(1, 0) == 1) fix_checksum();
      nbits = ($urandom_range(2, 0) == 0) ? int'($urandom_range(FW - 1, 1)) : FW;
      run_and_check("random", nbits);
      tick(3);
    end
  endtask

`ifdef MYO_SPI_RESP_CHECKSUM_EN
  task automatic test_checksum();
    logic [W-1:0] s;
    for (int k = 0; k < N - 1; k++) mosi_words[k] = W'(k + 1);
    for (int k = 0; k < N; k++) tx_data[k*W +: W] = W'($urandom);
    mosi_words[N-1] = 16'h0042;
    run_and_check("csum_good", FW);
    compared++;
    if (last_good[(N-1)*W +: W] !== 16'h0042) begin
      mismatched++;
      $display("FAIL csum_good_word: got %h expected 0042", last_good[(N-1)*W +: W]);
    end
    mosi_words[N-1] = 16'h0043;
    run_and_check("csum_bad", FW);
    s = '0;
    for (int k = 0; k < N - 1; k++) s = s + tx_data[k*W +: W];
    compared++;
    if (miso_word(N - 1) !== s) begin
      mismatched++;
      $display("FAIL csum_tx_last: got %h expected %h", miso_word(N - 1), s);
    end
  endtask
`endif

  initial begin
    spi_if.ss_n = 1'b1;
    spi_if.sck  = 1'b0;
    spi_if.mosi = 1'b0;
    test_reset();
    test_nominal();
    test_short();
    test_overrun();
    test_snapshot();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef MYO_SPI_RESP_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/myo_spi_responder.md
# myo_spi_responder

SPI slave that emulates the motor-board end of the myocontrol SPI link: it answers the FPGA-side SPI master (ss_n/sck/mosi/miso) with a frame of status words and captures the command words the master shifts in. It sits in the fabric as a loopback/bring-up target and hardware-in-the-loop stand-in for a muscle unit. It oversamples the SPI pins in the system clock domain.

## Interface

- `WORD_W`, 16: bits per SPI word, MSB first.
- `NUM_WORDS`, 12: words per frame.
- `clk` in 1: system clock; must be ≥ 8× the sck frequency.
- `reset` in 1: synchronous, active-high.
- `ss_n` in 1: frame select, active low, asynchronous to clk.
- `sck` in 1: SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous.
- `mosi` in 1: master-to-slave data.
- `miso` out 1: slave-to-master data.
- `miso_oe` out 1: high while the frame is selected.
- `tx_data` in NUM_WORDS*WORD_W: status words. Word k is at bits [(k+1)*WORD_W-1 : k*WORD_W].
- `rx_data` out NUM_WORDS*WORD_W: last good received frame, same packing.
- `rx_valid` out 1: one-cycle pulse when rx_data is updated.
- `rx_err` out 1: one-cycle pulse when a frame is malformed.
- `busy` out 1: high while the frame is in progress.

## Operation

- Input conditioning: ss_n, sck and mosi each pass through a 2-flop synchronizer plus one edge register. Rising and falling sck edges and the ss_n falling edge are derived from the synchronized signals.
- States:
  - IDLE: waits for the synchronized ss_n to fall.
  - SHIFT: on the ss_n fall, snapshots tx_data into the tx buffer, loads word 0 into the shift register, clears the counters and enters SHIFT.
  - SHIFT, rising sck: shifts the synchronized mosi into rx_shift and increments bit_cnt.
    - When bit_cnt wraps at WORD_W-1, rx_shift is written to rx_buf[word_cnt] and word_cnt increments.
  - SHIFT, falling sck: drives the next tx bit on miso. At a word boundary it loads tx_buf[word_cnt].
  - SHIFT, ss_n rises: go to DONE.
  - DONE: lasts one cycle.
    - Good frame (word_cnt == NUM_WORDS, bit_cnt == 0, no overrun): copy rx_buf to rx_data and pulse rx_valid.
    - Otherwise: pulse rx_err and leave rx_data unchanged.
    - Then return to IDLE.
- Overrun: sck rising edges beyond NUM_WORDS*WORD_W bits set the overrun flag. Those bits are discarded and miso is 0.
- Partial frame: ss_n rising mid-word, or with fewer than NUM_WORDS words, gives rx_err.
- Outputs:
  - miso is 0 and miso_oe is 0 outside SHIFT.
  - busy is high in SHIFT and DONE.
- Reset:
  - All outputs go to 0, including rx_data; the FSM goes to IDLE.
  - If ss_n is low when reset releases, the block ignores the rest of that frame. It arms only after it has seen the synchronized ss_n high.

## Timing

- Pin-to-internal latency is 3 clk (2 synchronizer flops + 1 edge register).
- miso carries the MSB of word 0 within 4 clk of the ss_n pin falling. The master must leave ≥ 5 clk between the ss_n fall and the first sck rise.
- Each later miso bit changes ≤ 4 clk after the sck pin falls.
- rx_valid / rx_err are asserted exactly 4 clk after the ss_n pin rises, and last 1 clk.
- tx_data changes after the snapshot do not affect the current frame.
- If the ss_n fall is seen in the same cycle as DONE, it is held pending and the next frame starts in the following cycle.

## Configuration

- `MYO_SPI_RESP_CHECKSUM_EN` defined:
  - Transmit: tx word NUM_WORDS-1 is replaced by the sum mod 2^WORD_W of tx words 0..NUM_WORDS-2.
  - Receive: rx word NUM_WORDS-1 is checked against the same sum of rx words 0..NUM_WORDS-2. A mismatch gives rx_err and no rx_valid.
- `MYO_SPI_RESP_CHECKSUM_EN` undefined: every word is passed through unchanged and no check is made.

## Structure

- Package `myo_spi_pkg` holds:
  - default WORD_W / NUM_WORDS constants;
  - the state enum: IDLE, SHIFT, DONE;
  - the SYNC_STAGES = 2 constant.
- Sub-module `myo_spi_sync`: generic single-bit synchronizer with rise/fall pulse outputs. It is instantiated once each for ss_n, sck and mosi; the rise/fall outputs of the mosi instance are unused.

## Test plan

- Nominal frame: NUM_WORDS=12, sck = clk/10; master sends words 0x1000+k; tx word k is 0xA000+k.
  - miso returns 0xA000..0xA00B.
  - rx_data matches the sent words and rx_valid pulses once, 4 clk after ss_n rises.
- Short frame: ss_n rises after 5 words + 3 bits → rx_err pulses, rx_valid stays 0, rx_data is unchanged.
- Overrun: 12 words + 8 extra bits with tx word 0 = 0xFFFF → miso is 0 during the extra bits, then rx_err.
- Snapshot: tx_data changes mid-frame → miso shows only the values captured at the ss_n fall.
- Reset: reset during word 4 with ss_n held low → no rx_valid/rx_err for that frame. A frame started after ss_n goes high completes normally.
- With `MYO_SPI_RESP_CHECKSUM_EN`:
  - rx words 0..10 = 1..11 with last word 0x0042 → rx_valid.
  - Same frame with last word 0x0043 → rx_err.
  - tx last word equals the sum of tx words 0..10.
